// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of pwm_in in clk cycles.
// Optional glitch filter between synchronizer and edge detector: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int W        = 16,
  parameter int TIMEOUT  = 65535,
  parameter int FILT_LEN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] high_time,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         lost
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0] ONE       = W'(1);

  state_t       state, state_nxt;
  logic [W-1:0] pcnt, pcnt_nxt;
  logic [W-1:0] hcnt, hcnt_nxt;
  logic         sync1, s, s_f, s_d;
  logic         rise, fall;
  logic         capture, timeout;

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);
  localparam logic [FW-1:0] FONE  = FW'(1);

  logic          filt;
  logic [FW-1:0] fcnt;

  // Filter output follows s only after FILT_LEN consecutive differing cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (s == filt) begin
      fcnt <= '0;
    end else if (fcnt == FLAST) begin
      filt <= s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FONE;
    end
  end

  assign s_f = filt;
`else
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN > 0);
  assign s_f = s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s_f;
  end

  assign rise = s_f & ~s_d;
  assign fall = ~s_f & s_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // A rise on the timeout cycle still completes the measurement
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    hcnt_nxt  = hcnt;
    capture   = 1'b0;
    timeout   = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      pcnt_nxt  = '0;
      hcnt_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          pcnt_nxt = '0;
          hcnt_nxt = '0;
          if (rise) begin
            state_nxt = HIGH;
            pcnt_nxt  = ONE;
            hcnt_nxt  = ONE;
          end
        end
        HIGH: begin
          if (pcnt == TIMEOUT_W) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            hcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + ONE;
            if (fall) state_nxt = LOW;
            else      hcnt_nxt  = hcnt + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            capture   = 1'b1;
            state_nxt = HIGH;
            pcnt_nxt  = ONE;
            hcnt_nxt  = ONE;
          end else if (pcnt == TIMEOUT_W) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            hcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          pcnt_nxt  = '0;
          hcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      lost      <= 1'b1;
    end else begin
      valid <= capture;
      if (capture) begin
        period    <= pcnt;
        high_time <= hcnt;
        lost      <= 1'b0;
      end else if (timeout || !en) begin
        lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: two instances (TIMEOUT 2000 and 100) with a cycle model
// that pushes expected measurements as the waveform is driven.
module tb_pwm_capture;

  localparam int W    = 16;
  localparam int TO_A = 2000;
  localparam int TO_B = 100;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FL  = 4;
  localparam int LAT = 4;
`else
  localparam int FL  = 1;
  localparam int LAT = 0;
`endif

  typedef struct {
    int h;
    int p;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, en, pwm_a, pwm_b;
  logic [W-1:0] high_time_a, period_a, high_time_b, period_b;
  logic         valid_a, lost_a, valid_b, lost_b;

  int checks   = 0;
  int failures = 0;

  exp_t qA[$];
  exp_t qB[$];

  logic mFlt[2], mLast[2], mActive[2];
  int   mFcnt[2], mPc[2], mHc[2];
  int   mTo[2] = '{TO_A, TO_B};

  always #5 clk = ~clk;

  pwm_capture #(.W(W), .TIMEOUT(TO_A), .FILT_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_a),
    .high_time(high_time_a), .period(period_a), .valid(valid_a), .lost(lost_a)
  );

  pwm_capture #(.W(W), .TIMEOUT(TO_B), .FILT_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_b),
    .high_time(high_time_b), .period(period_b), .valid(valid_b), .lost(lost_b)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Behavioural model: one call per clock, with the level driven during that cycle
  task automatic modelStep(input int i, input logic lvl);
    logic rise;
    exp_t e;
    if (!rst_n) begin
      mFlt[i] = 1'b0; mLast[i] = 1'b0; mActive[i] = 1'b0;
      mFcnt[i] = 0; mPc[i] = 0; mHc[i] = 0;
      return;
    end
    if (lvl != mFlt[i]) begin
      mFcnt[i]++;
      if (mFcnt[i] >= FL) begin
        mFlt[i]  = lvl;
        mFcnt[i] = 0;
      end
    end else begin
      mFcnt[i] = 0;
    end
    rise     = mFlt[i] & ~mLast[i];
    mLast[i] = mFlt[i];
    if (!en) begin
      mActive[i] = 1'b0;
    end else if (rise) begin
      if (mActive[i]) begin
        e.h = mHc[i];
        e.p = mPc[i];
        if (i == 0) qA.push_back(e);
        else        qB.push_back(e);
      end
      mActive[i] = 1'b1;
      mPc[i] = 1;
      mHc[i] = 1;
    end else if (mActive[i]) begin
      mPc[i]++;
      if (mFlt[i]) mHc[i]++;
      if (mPc[i] > mTo[i]) mActive[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    modelStep(0, pwm_a);
    modelStep(1, pwm_b);
  endtask

  task automatic setLevel(input int i, input logic lvl, input int n);
    if (i == 0) pwm_a = lvl;
    else        pwm_b = lvl;
    repeat (n) step();
  endtask

  task automatic applyStimulus(input int i, input int hi, input int per, input int cnt);
    repeat (cnt) begin
      setLevel(i, 1'b1, hi);
      setLevel(i, 1'b0, per - hi);
    end
  endtask

  // Scoreboard: every valid strobe must match the oldest expected measurement
  always @(negedge clk) begin : monitor
    exp_t ea, eb;
    if (valid_a === 1'b1) begin
      checkOutput("a_valid_expected", int'(qA.size() > 0), 1);
      if (qA.size() > 0) begin
        ea = qA.pop_front();
        checkOutput("a_high_time", int'(high_time_a), ea.h);
        checkOutput("a_period", int'(period_a), ea.p);
        checkOutput("a_lost_at_valid", int'(lost_a), 0);
      end
    end
    if (valid_b === 1'b1) begin
      checkOutput("b_valid_expected", int'(qB.size() > 0), 1);
      if (qB.size() > 0) begin
        eb = qB.pop_front();
        checkOutput("b_high_time", int'(high_time_b), eb.h);
        checkOutput("b_period", int'(period_b), eb.p);
        checkOutput("b_lost_at_valid", int'(lost_b), 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    repeat (4) step();
    checkOutput("reset_high_time", int'(high_time_a), 0);
    checkOutput("reset_period", int'(period_a), 0);
    checkOutput("reset_valid", int'(valid_a), 0);
    checkOutput("reset_lost", int'(lost_a), 1);
    checkOutput("reset_lost_b", int'(lost_b), 1);
    rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] steady 300/1024, then 700/1024");
    applyStimulus(0, 300, 1024, 3);
    checkOutput("steady_lost", int'(lost_a), 0);
    checkOutput("steady_high_time", int'(high_time_a), 300);
    checkOutput("steady_period", int'(period_a), 1024);
    applyStimulus(0, 700, 1024, 2);

    $display("[TB] stuck high with TIMEOUT=2000");
    setLevel(0, 1'b1, 2002 + LAT);
    checkOutput("stuck_lost_before", int'(lost_a), 0);
    step();
    checkOutput("stuck_lost_after", int'(lost_a), 1);
    checkOutput("stuck_hold_high_time", int'(high_time_a), 700);
    checkOutput("stuck_hold_period", int'(period_a), 1024);
    setLevel(0, 1'b1, 100);
    checkOutput("stuck_lost_stays", int'(lost_a), 1);
    setLevel(0, 1'b0, 30);
    applyStimulus(0, 10, 50, 3);
    checkOutput("resume_high_time", int'(high_time_a), 10);
    checkOutput("resume_period", int'(period_a), 50);
    checkOutput("resume_lost", int'(lost_a), 0);

    $display("[TB] boundary with TIMEOUT=100");
    applyStimulus(1, 30, 100, 3);
    checkOutput("bound_period_100", int'(period_b), 100);
    checkOutput("bound_lost_100", int'(lost_b), 0);
    applyStimulus(1, 30, 101, 2);
    checkOutput("bound_lost_101", int'(lost_b), 1);
    checkOutput("bound_hold_period", int'(period_b), 100);
    checkOutput("bound_hold_high_time", int'(high_time_b), 30);

    $display("[TB] enable drop mid-period");
    applyStimulus(0, 300, 1024, 2);
    setLevel(0, 1'b1, 100);
    en = 1'b0;
    setLevel(0, 1'b1, 5);
    checkOutput("en_lost", int'(lost_a), 1);
    checkOutput("en_hold_high_time", int'(high_time_a), 300);
    checkOutput("en_hold_period", int'(period_a), 1024);
    en = 1'b1;
    setLevel(0, 1'b1, 195);
    setLevel(0, 1'b0, 724);
    applyStimulus(0, 300, 1024, 3);

    $display("[TB] reset mid-period");
    setLevel(0, 1'b1, 300);
    setLevel(0, 1'b0, 200);
    rst_n = 1'b0;
    setLevel(0, 1'b0, 5);
    checkOutput("rst_high_time", int'(high_time_a), 0);
    checkOutput("rst_period", int'(period_a), 0);
    checkOutput("rst_lost", int'(lost_a), 1);
    rst_n = 1'b1;
    setLevel(0, 1'b0, 519);
    applyStimulus(0, 300, 1024, 3);
    checkOutput("rst_recover_period", int'(period_a), 1024);

`ifdef PWM_CAPTURE_FILTER_EN
    $display("[TB] glitch filter");
    setLevel(0, 1'b0, 50);
    repeat (3) begin
      setLevel(0, 1'b1, 40);
      setLevel(0, 1'b0, 20);
      setLevel(0, 1'b1, 3);
      setLevel(0, 1'b0, 37);
    end
    checkOutput("filt_high_time", int'(high_time_a), 40);
    checkOutput("filt_period", int'(period_a), 100);
    setLevel(0, 1'b1, 4);
    setLevel(0, 1'b0, 96);
    setLevel(0, 1'b1, 40);
    setLevel(0, 1'b0, 60);
    checkOutput("filt_short_high_time", int'(high_time_a), 4);
    checkOutput("filt_short_period", int'(period_a), 100);
`endif

    setLevel(0, 1'b0, 50);
    checkOutput("a_pending_expected", qA.size(), 0);
    checkOutput("b_pending_expected", qB.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
